comm_host: RTL and testbench
============================

Name: comm_host

Overview:
- Host-side initiator for the `comm` serial command protocol.
- Serialises one command byte onto `serial_tx` as UART 8N1, then collects a fixed number of response bytes from `serial_rx`.
- Assembles the response bytes into a 32-bit word and signals completion.
- Sits opposite `comm` on the serial link; used by a controller or bench that needs to read the pin map or enable mask.

Parameters:
- CLK_PER_BIT, 16, clock cycles per UART bit; must be even and at least 4.
- TIMEOUT_BITS, 64, response timeout in bit-times; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cmd  input  8  command byte; sampled on the cycle `start` is accepted.
- resp_len  input  3  number of response bytes expected, 0..4; sampled with `cmd`.
- start  input  1  request pulse; accepted only while `busy`=0.
- busy  output  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- done  output  1  one-cycle completion pulse.
- resp_data  output  32  assembled response word.
- frame_err  output  1  sticky flag; set if any response byte has a stop bit of 0.
- timeout  output  1  high with `done` when the transaction ended by timeout.
- serial_rx  input  1  UART line from `comm`.
- serial_tx  output  1  UART line to `comm`.

Behaviour:
- Reset values: `serial_tx`=1, `busy`=0, `done`=0, `resp_data`=0, `frame_err`=0, `timeout`=0.
- States: IDLE, TX, RX_WAIT, RX_BYTE, FINISH.
- Reset is asynchronous. Asserting `rst` mid-transaction aborts immediately and returns all state and outputs to reset values. No `done` pulse is generated.
- IDLE -> TX when `start`=1.
  - Latch `cmd` and `resp_len`.
  - Clear `resp_data`, `frame_err` and `timeout`.
  - Raise `busy`.
- TX:
  - Start bit (0) drives `serial_tx` from the cycle after acceptance.
  - Then 8 data bits, LSB first, then a stop bit (1). Each bit lasts exactly CLK_PER_BIT cycles, so the frame is 10*CLK_PER_BIT cycles.
  - At the end of the stop bit: go to RX_WAIT, or to FINISH if `resp_len`=0.
- RX_WAIT:
  - Detect a falling edge on `serial_rx`. The input passes through a two-flop synchroniser first.
  - Re-check the line at CLK_PER_BIT/2 cycles after the edge. If it is still 0, go to RX_BYTE. If it is 1, treat it as a glitch and stay in RX_WAIT.
- RX_BYTE:
  - Sample each of the 8 data bits, LSB first, at its bit centre (every CLK_PER_BIT cycles).
  - Sample the stop bit at its centre. If it is 0, set `frame_err`; the byte is still stored.
  - Byte k (k = 0..resp_len-1) is written to `resp_data[8k+:8]`. Upper unused bytes stay 0.
  - Increment the received count. If count == `resp_len`, go to FINISH; otherwise return to RX_WAIT.
- FINISH: lasts one cycle.
  - `done`=1, `busy`=0, then back to IDLE.
  - `done` asserts on the cycle after the last stop-bit sample.
- `resp_data`, `frame_err` and `timeout` hold their values until the next accepted `start`.
- `start` while `busy`=1 is ignored; no queueing.
- Bytes arriving on `serial_rx` while in IDLE are discarded.
- `resp_len` values 5..7 are clamped to 4.
- `start` in the same cycle as FINISH is ignored. A new `start` is accepted from the following cycle, so back-to-back transactions are allowed.

Optional Feature:
- Macro: COMM_HOST_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in RX_WAIT and restarts at every entry to RX_WAIT.
  - If no start bit is confirmed within TIMEOUT_BITS*CLK_PER_BIT cycles, go to FINISH with `timeout`=1 on the `done` cycle and held afterwards.
  - `resp_data` keeps whatever bytes were already received.
- Without the macro:
  - `timeout` is tied to 0 and no counter logic exists.
  - RX_WAIT waits indefinitely; only `rst` recovers the block.

Test Plan:
- Read pin map: `cmd`=COMM_READ_PIN_MAP, `resp_len`=4, connected to `comm` -> `serial_tx` frame carries the command byte LSB first; one `done` pulse; `resp_data`=32'haabbccdd; `frame_err`=0.
- Read enable mask twice back-to-back: `cmd`=COMM_READ_ENABLE_MASK, `resp_len`=2, second `start` on the cycle after `done` -> both runs give `resp_data`=32'h0000aa55.
- `start` pulsed mid-TX with a different `cmd` -> ignored; transmitted byte unchanged; exactly one `done`.
- Responder model sends 8'h5a with a stop bit of 0, `resp_len`=1 -> `done` pulses; `resp_data`=32'h0000005a; `frame_err`=1; flag cleared on next `start`.
- `rst` asserted during the second of four response bytes -> `serial_tx`=1, `busy`=0, `resp_data`=0 asynchronously; no `done` pulse; next transaction completes normally.
- With COMM_HOST_TIMEOUT_EN, `resp_len`=3, responder sends only 8'h11 -> `done` fires TIMEOUT_BITS*CLK_PER_BIT cycles after that byte's stop sample (±2 cycles of synchroniser latency); `timeout`=1; `resp_data`=32'h00000011.

Source files
------------

// File: rtl/comm_host.sv
// comm_host: UART 8N1 command initiator. Sends one command byte, then collects 0..4 response bytes into resp_data.
// COMM_HOST_TIMEOUT_EN bounds the response wait. A start pulse while busy is dropped, not queued.
module comm_host #(
   parameter int CLK_PER_BIT  = 16,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd,
   input  logic [2:0]  resp_len,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] resp_data,
   output logic        frame_err,
   output logic        timeout,
   input  logic        serial_rx,
   output logic        serial_tx
);

   typedef enum logic [2:0] {IDLE, TX, RX_WAIT, RX_BYTE, FINISH} state_t;

   localparam int            CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

   if (CLK_PER_BIT < 4 || (CLK_PER_BIT % 2) != 0 || TIMEOUT_BITS < 1) begin : g_bad_params
      $error("comm_host: CLK_PER_BIT must be even and >= 4, TIMEOUT_BITS >= 1");
   end

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    tx_sr;
   logic [7:0]    rx_sr;
   logic [2:0]    len_q;
   logic [2:0]    byte_cnt;
   logic          rx_s1, rx_s2, rx_prev, rx_arm;
   logic [2:0]    len_clamp;
   logic [2:0]    byte_nxt;
   logic          start_ok;

   assign len_clamp = (resp_len > 3'd4) ? 3'd4 : resp_len;
   assign byte_nxt  = byte_cnt + 3'd1;
   // start bit survives the half-bit re-check this cycle
   assign start_ok  = rx_arm && (clk_cnt == HALF_LAST) && !rx_s2;

`ifdef COMM_HOST_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_BITS * CLK_PER_BIT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS * CLK_PER_BIT - 1);
   logic [TW-1:0] to_cnt;
   logic          to_q;
   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= serial_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         serial_tx <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         resp_data <= '0;
         frame_err <= 1'b0;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '1;
         rx_sr     <= '0;
         len_q     <= '0;
         byte_cnt  <= '0;
         rx_arm    <= 1'b0;
`ifdef COMM_HOST_TIMEOUT_EN
         to_cnt    <= '0;
         to_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= TX;
                  tx_sr     <= {1'b1, cmd};
                  serial_tx <= 1'b0;
                  len_q     <= len_clamp;
                  resp_data <= '0;
                  frame_err <= 1'b0;
                  busy      <= 1'b1;
                  clk_cnt   <= '0;
                  bit_cnt   <= '0;
                  byte_cnt  <= '0;
`ifdef COMM_HOST_TIMEOUT_EN
                  to_q      <= 1'b0;
`endif
               end
            end
            TX: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 4'd9) begin
                     rx_arm <= 1'b0;
`ifdef COMM_HOST_TIMEOUT_EN
                     to_cnt <= '0;
`endif
                     if (len_q == 3'd0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state <= RX_WAIT;
                     end
                  end else begin
                     // tx_sr backfills with 1 so the stop bit falls out after data bit 7
                     serial_tx <= tx_sr[0];
                     tx_sr     <= {1'b1, tx_sr[8:1]};
                     bit_cnt   <= bit_cnt + 4'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_WAIT: begin
               if (!rx_arm) begin
                  if (rx_prev && !rx_s2) begin
                     rx_arm  <= 1'b1;
                     clk_cnt <= '0;
                  end
               end else if (clk_cnt == HALF_LAST) begin
                  rx_arm  <= 1'b0;
                  clk_cnt <= '0;
                  if (!rx_s2) begin
                     state   <= RX_BYTE;
                     bit_cnt <= '0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
`ifdef COMM_HOST_TIMEOUT_EN
               to_cnt <= to_cnt + 1'b1;
               if (to_cnt == TO_LAST && !start_ok) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  to_q  <= 1'b1;
               end
`endif
            end
            RX_BYTE: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 4'd8) begin
                     // stop-bit centre: a bad stop bit is flagged but the byte is kept
                     frame_err <= frame_err | ~rx_s2;
                     resp_data[{byte_cnt[1:0], 3'b000} +: 8] <= rx_sr;
                     byte_cnt  <= byte_nxt;
                     rx_arm    <= 1'b0;
`ifdef COMM_HOST_TIMEOUT_EN
                     to_cnt    <= '0;
`endif
                     if (byte_nxt == len_q) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state <= RX_WAIT;
                     end
                  end else begin
                     rx_sr   <= {rx_s2, rx_sr[7:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = start_ok;

endmodule

// File: tb/tb_comm_host.sv
// Directed bench for comm_host: decodes serial_tx frames and plays a UART responder on serial_rx.
module tb_comm_host;
   localparam int CPB     = 16;
   localparam int TO_BITS = 64;
   localparam logic [7:0] COMM_READ_PIN_MAP     = 8'h01;
   localparam logic [7:0] COMM_READ_ENABLE_MASK = 8'h02;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cmd = 8'h00;
   logic [2:0]  resp_len = 3'd0;
   logic        start = 1'b0;
   logic        serial_rx = 1'b1;
   logic        busy, done, frame_err, timeout, serial_tx;
   logic [31:0] resp_data;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int cyc = 0;
   int done_cyc = 0;
   int stop_cyc = 0;

   comm_host #(.CLK_PER_BIT(CPB), .TIMEOUT_BITS(TO_BITS)) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .resp_len(resp_len), .start(start),
      .busy(busy), .done(done), .resp_data(resp_data), .frame_err(frame_err),
      .timeout(timeout), .serial_rx(serial_rx), .serial_tx(serial_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue a start and decode the transmitted frame at each bit centre.
   task automatic run_tx(input logic [7:0] c, input logic [2:0] l, input int pulse_n, input logic [7:0] pulse_c);
      logic [9:0] frame;
      frame = '0;
      cmd = c; resp_len = l; start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 10*CPB; n++) begin
         @(negedge clk);
         if (n == 0) begin start = 1'b0; check("busy_after_start", busy, 1); end
         if (n == pulse_n) begin start = 1'b1; cmd = pulse_c; end
         if (n == pulse_n + 1) start = 1'b0;
         if (n % CPB == CPB/2) frame[n/CPB] = serial_tx;
      end
      check("tx_start_bit", frame[0], 0);
      check("tx_data", frame[8:1], c);
      check("tx_stop_bit", frame[9], 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit wait_done);
      bit seen;
      seen = 1'b0;
      serial_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      serial_rx = stop_v;
      for (int n = 0; n < CPB; n++) begin
         @(negedge clk);
         if (n == CPB/2 - 1) stop_cyc = cyc;
         if (wait_done && done === 1'b1) begin seen = 1'b1; break; end
      end
      serial_rx = 1'b1;
      if (wait_done) check("done_after_last_byte", seen, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_serial_tx", serial_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_frame_err", frame_err, 0);
      check("rst_timeout", timeout, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Read pin map, four bytes LSB-byte first
      run_tx(COMM_READ_PIN_MAP, 3'd4, -1, 8'h00);
      send_byte(8'hdd, 1'b1, 1'b0);
      send_byte(8'hcc, 1'b1, 1'b0);
      send_byte(8'hbb, 1'b1, 1'b0);
      send_byte(8'haa, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      check("pinmap_done_cnt", done_cnt, 1);
      check("pinmap_resp", resp_data, 32'haabbccdd);
      check("pinmap_frame_err", frame_err, 0);
      check("pinmap_timeout", timeout, 0);
      check("pinmap_busy", busy, 0);

      // Enable mask back-to-back; a start in the FINISH cycle must be dropped
      run_tx(COMM_READ_ENABLE_MASK, 3'd2, -1, 8'h00);
      send_byte(8'h55, 1'b1, 1'b0);
      send_byte(8'haa, 1'b1, 1'b1);
      check("mask1_resp_on_done", resp_data, 32'h0000aa55);
      check("mask1_busy_on_done", busy, 0);
      start = 1'b1;
      @(negedge clk);
      check("finish_start_ignored", busy, 0);
      run_tx(COMM_READ_ENABLE_MASK, 3'd2, -1, 8'h00);
      check("mask2_resp_cleared", resp_data, 32'h0);
      send_byte(8'h55, 1'b1, 1'b0);
      send_byte(8'haa, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      check("mask2_resp", resp_data, 32'h0000aa55);
      check("mask_done_cnt", done_cnt, 3);

      // Bad stop bit is flagged, byte still stored
      run_tx(8'h10, 3'd1, -1, 8'h00);
      send_byte(8'h5a, 1'b0, 1'b0);
      repeat (CPB) @(negedge clk);
      check("ferr_done_cnt", done_cnt, 4);
      check("ferr_resp", resp_data, 32'h0000005a);
      check("ferr_flag", frame_err, 1);

      // start mid-TX ignored; resp_len 7 behaves as 4
      run_tx(8'hc3, 3'd7, 45, 8'h3c);
      check("ferr_cleared", frame_err, 0);
      check("midtx_resp_cleared", resp_data, 32'h0);
      send_byte(8'h01, 1'b1, 1'b0);
      send_byte(8'h02, 1'b1, 1'b0);
      send_byte(8'h03, 1'b1, 1'b0);
      send_byte(8'h04, 1'b1, 1'b0);
      repeat (2*CPB) @(negedge clk);
      check("midtx_done_cnt", done_cnt, 5);
      check("clamp_resp", resp_data, 32'h04030201);
      check("midtx_busy", busy, 0);

      // Reset during the second response byte
      run_tx(COMM_READ_PIN_MAP, 3'd4, -1, 8'h00);
      send_byte(8'h12, 1'b1, 1'b0);
      check("partial_byte0", resp_data, 32'h00000012);
      serial_rx = 1'b0; repeat (CPB) @(negedge clk);
      serial_rx = 1'b1; repeat (CPB) @(negedge clk);
      serial_rx = 1'b0; repeat (CPB) @(negedge clk);
      serial_rx = 1'b1; repeat (CPB/2) @(negedge clk);
      rst = 1'b1;
      #2;
      check("async_rst_serial_tx", serial_tx, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_resp", resp_data, 32'h0);
      check("async_rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3*CPB) @(negedge clk);
      check("rst_no_done", done_cnt, 5);
      run_tx(COMM_READ_ENABLE_MASK, 3'd1, -1, 8'h00);
      send_byte(8'h77, 1'b1, 1'b0);
      repeat (2*CPB) @(negedge clk);
      check("post_rst_done_cnt", done_cnt, 6);
      check("post_rst_resp", resp_data, 32'h00000077);

`ifdef COMM_HOST_TIMEOUT_EN
      // Only one of three bytes arrives
      run_tx(COMM_READ_ENABLE_MASK, 3'd3, -1, 8'h00);
      send_byte(8'h11, 1'b1, 1'b0);
      for (int n = 0; n < TO_BITS*CPB + 64; n++) begin
         if (done_cnt == 7) break;
         @(negedge clk);
      end
      check("to_done_cnt", done_cnt, 7);
      // stop sample lands 3 cycles after the bench's stop centre through the synchroniser
      check("to_latency", ((done_cyc - stop_cyc) >= TO_BITS*CPB + 1) &&
                          ((done_cyc - stop_cyc) <= TO_BITS*CPB + 5), 1);
      check("to_resp", resp_data, 32'h00000011);
      repeat (5) @(negedge clk);
      check("to_flag_held", timeout, 1);
      check("to_busy", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
